// File: rtl/vid_mode_pkg.sv
// Shared definitions for the video processing-mode select path.
// Used by the mode select controller and by the output mux decoder.
package vid_mode_pkg;

  localparam int unsigned MODE_W = 4;

  typedef logic [MODE_W-1:0] mode_t;

  // Processing modes, in the order the buttons step through them
  localparam int unsigned MODE_RAW          = 0;
  localparam int unsigned MODE_GRAY         = 1;
  localparam int unsigned MODE_MEDIAN       = 2;
  localparam int unsigned MODE_SOBEL        = 3;
  localparam int unsigned MODE_PREWITT      = 4;
  localparam int unsigned MODE_SOBEL_ERODE  = 5;
  localparam int unsigned MODE_SOBEL_DILATE = 6;
  localparam int unsigned MODE_GESTURE      = 7;
  localparam int unsigned NUM_MODES_DEF     = 8;

  // Step forward through num_modes modes, wrapping to 0
  function automatic mode_t mode_inc(input mode_t m, input int unsigned num_modes);
    return (32'(m) == num_modes - 1) ? '0 : MODE_W'(m + 1'b1);
  endfunction

  // Step backward through num_modes modes, wrapping to the last mode
  function automatic mode_t mode_dec(input mode_t m, input int unsigned num_modes);
    return (m == '0) ? MODE_W'(num_modes - 1) : MODE_W'(m - 1'b1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on each accepted 1->0 transition of the key.
//   clk    in  system clock
//   rst    in  synchronous reset, active-high
//   key_n  in  raw active-low button, asynchronous to clk
//   press  out one-cycle pulse when the debounced level goes to pressed
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Synchroniser, stability counter and press pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
        // Old level 1 means this flip is a press; releases give no pulse
        press  <= stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mode_select_ctrl.sv
// Processing-mode select for the video output mux. Two debounced buttons
// step a target mode; the target is committed to mode_sel on a frame
// boundary (or immediately when SYNC_TO_FRAME=0) so frames never tear.
//   sys_clk       in  system clock
//   sys_rst       in  synchronous reset, active-high
//   key_next_n    in  raw "next mode" button, active-low, async
//   key_prev_n    in  raw "previous mode" button, active-low, async
//   frame_vsync   in  camera vsync, active-high, async; rising = frame start
//   mode_sel      out committed mode, drives the mux select
//   mode_led      out one-hot of mode_sel for the indicator LEDs
//   mode_pending  out target differs from mode_sel (combinational)
//   mode_changed  out one-cycle pulse when mode_sel updates
module mode_select_ctrl
  import vid_mode_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 1_000_000,
  parameter int unsigned NUM_MODES     = NUM_MODES_DEF,
  parameter int unsigned RESET_MODE    = MODE_RAW,
  parameter int unsigned SYNC_TO_FRAME = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 key_next_n,
  input  logic                 key_prev_n,
  input  logic                 frame_vsync,
  output logic [MODE_W-1:0]    mode_sel,
  output logic [NUM_MODES-1:0] mode_led,
  output logic                 mode_pending,
  output logic                 mode_changed
);

  logic  next_press;
  logic  prev_press;
  logic  vs_s1;
  logic  vs_s2;
  logic  vs_s3;
  logic  vs_edge_c;
  logic  commit_c;
  mode_t target;
  logic [NUM_MODES-1:0] led_c;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .key_n (key_next_n),
    .press (next_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .key_n (key_prev_n),
    .press (prev_press)
  );

  // Vsync synchroniser plus one extra stage for rising-edge detection
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
      vs_s3 <= 1'b0;
    end else begin
      vs_s1 <= frame_vsync;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
    end
  end

  assign vs_edge_c = vs_s2 & ~vs_s3;

  // Target mode; simultaneous next and prev cancel out
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      target <= MODE_W'(RESET_MODE);
    end else if (next_press && !prev_press) begin
      target <= mode_inc(target, NUM_MODES);
    end else if (prev_press && !next_press) begin
      target <= mode_dec(target, NUM_MODES);
    end
  end

  assign mode_pending = (target != mode_sel);

  // Without frame sync the target is committed as soon as it differs
  assign commit_c = (SYNC_TO_FRAME != 0) ? (vs_edge_c && mode_pending) : mode_pending;

  assign led_c = NUM_MODES'(1) << target;

  // Commit register; reads the pre-update target, so a key event that
  // coincides with a vsync edge stays pending until the next frame
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mode_sel     <= MODE_W'(RESET_MODE);
      mode_led     <= NUM_MODES'(1) << RESET_MODE;
      mode_changed <= 1'b0;
    end else begin
      mode_changed <= commit_c;
      if (commit_c) begin
        mode_sel <= target;
        mode_led <= led_c;
      end
    end
  end

endmodule

// File: tb/tb_mode_select_ctrl.sv
module tb_mode_select_ctrl;

  localparam int DEB = 4;
  localparam int N   = 8;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       key_next_n = 1'b1;
  logic       key_prev_n = 1'b1;
  logic       frame_vsync = 1'b0;
  logic       k0_next_n = 1'b1;
  logic       k0_prev_n = 1'b1;
  logic       vs0 = 1'b0;

  logic [3:0] sel1, sel0;
  logic [7:0] led1, led0;
  logic       pend1, pend0, chg1, chg0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mode_select_ctrl #(.DEB_CYCLES(DEB), .NUM_MODES(N), .RESET_MODE(0), .SYNC_TO_FRAME(1)) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .key_next_n(key_next_n), .key_prev_n(key_prev_n),
    .frame_vsync(frame_vsync), .mode_sel(sel1), .mode_led(led1),
    .mode_pending(pend1), .mode_changed(chg1)
  );

  mode_select_ctrl #(.DEB_CYCLES(DEB), .NUM_MODES(N), .RESET_MODE(0), .SYNC_TO_FRAME(0)) dut0 (
    .sys_clk(clk), .sys_rst(sys_rst), .key_next_n(k0_next_n), .key_prev_n(k0_prev_n),
    .frame_vsync(vs0), .mode_sel(sel0), .mode_led(led0),
    .mode_pending(pend0), .mode_changed(chg0)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: a key level is accepted once DEB consecutive
  // synchronised samples (raw delayed two cycles) disagree with it.
  bit         m_valid = 0;
  int         m_tgt[2];
  int         m_mode[2];
  bit         m_chg[2];
  bit         m_stab[2][2];
  bit         m_ev[2][2];
  logic [15:0] m_kh[2][2];
  logic [15:0] m_vh[2];

  task automatic model_step();
    bit rk[2][2];
    bit rv[2];
    rk[1][0] = key_next_n; rk[1][1] = key_prev_n; rv[1] = frame_vsync;
    rk[0][0] = k0_next_n;  rk[0][1] = k0_prev_n;  rv[0] = vs0;
    for (int i = 0; i < 2; i++) begin
      if (sys_rst) begin
        m_tgt[i] = 0; m_mode[i] = 0; m_chg[i] = 0;
        for (int k = 0; k < 2; k++) begin
          m_stab[i][k] = 1; m_ev[i][k] = 0; m_kh[i][k] = '1;
        end
        m_vh[i] = '0;
      end else begin
        bit edge_seen;
        bit newev[2];
        // history bit j holds the raw sample from j+1 edges ago
        edge_seen = m_vh[i][1] & ~m_vh[i][2];
        if (i == 1) begin
          m_chg[i] = edge_seen && (m_tgt[i] != m_mode[i]);
        end else begin
          m_chg[i] = (m_tgt[i] != m_mode[i]);
        end
        if (m_chg[i]) m_mode[i] = m_tgt[i];
        if (m_ev[i][0] && !m_ev[i][1]) m_tgt[i] = (m_tgt[i] + 1) % N;
        else if (m_ev[i][1] && !m_ev[i][0]) m_tgt[i] = (m_tgt[i] + N - 1) % N;
        for (int k = 0; k < 2; k++) begin
          bit all_diff;
          all_diff = 1;
          for (int j = 1; j <= DEB; j++)
            if (m_kh[i][k][j] == m_stab[i][k]) all_diff = 0;
          newev[k] = all_diff && m_stab[i][k];
          if (all_diff) m_stab[i][k] = ~m_stab[i][k];
        end
        m_ev[i][0] = newev[0];
        m_ev[i][1] = newev[1];
        for (int k = 0; k < 2; k++) m_kh[i][k] = {m_kh[i][k][14:0], rk[i][k]};
        m_vh[i] = {m_vh[i][14:0], rv[i]};
      end
    end
    if (sys_rst) m_valid = 1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-by-cycle comparison against the model on the falling edge
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("cyc_sel1",  int'(sel1),  m_mode[1]);
      chk("cyc_led1",  int'(led1),  1 << m_mode[1]);
      chk("cyc_pend1", int'(pend1), int'(m_tgt[1] != m_mode[1]));
      chk("cyc_chg1",  int'(chg1),  int'(m_chg[1]));
      chk("cyc_sel0",  int'(sel0),  m_mode[0]);
      chk("cyc_led0",  int'(led0),  1 << m_mode[0]);
      chk("cyc_pend0", int'(pend0), int'(m_tgt[0] != m_mode[0]));
      chk("cyc_chg0",  int'(chg0),  int'(m_chg[0]));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit nxt, input bit prv);
    if (nxt) key_next_n = 1'b0;
    if (prv) key_prev_n = 1'b0;
    tick(DEB + 6);
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    tick(DEB + 6);
  endtask

  task automatic vsync_pulse(output int pulses);
    pulses = 0;
    frame_vsync = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (chg1) pulses++;
    end
    frame_vsync = 1'b0;
    tick(4);
  endtask

  initial begin
    int p;
    int errs;
    tick(3);
    sys_rst = 1'b0;
    tick(1);
    chk("rst_sel", int'(sel1), 0);
    chk("rst_led", int'(led1), 8'h01);
    chk("rst_pend", int'(pend1), 0);
    chk("rst_chg", int'(chg1), 0);

    // 3-cycle glitch is rejected
    key_next_n = 1'b0;
    tick(3);
    key_next_n = 1'b1;
    tick(12);
    chk("glitch_pend", int'(pend1), 0);
    chk("glitch_sel", int'(sel1), 0);

    // Single next press: target moves exactly 7 cycles later
    key_next_n = 1'b0;
    tick(6);
    chk("lat_pend6", int'(pend1), 0);
    tick(1);
    chk("lat_pend7", int'(pend1), 1);
    tick(3);
    key_next_n = 1'b1;
    tick(10);
    chk("pend_hold", int'(pend1), 1);
    frame_vsync = 1'b1;
    tick(2);
    chk("pre_commit_chg", int'(chg1), 0);
    chk("pre_commit_sel", int'(sel1), 0);
    tick(1);
    chk("commit_sel", int'(sel1), 1);
    chk("commit_led", int'(led1), 8'h02);
    chk("commit_chg", int'(chg1), 1);
    chk("commit_pend", int'(pend1), 0);
    tick(1);
    chk("commit_chg_end", int'(chg1), 0);
    frame_vsync = 1'b0;
    tick(5);

    // Three presses in one frame commit once, 2 -> 5
    press(1, 0);
    vsync_pulse(p);
    chk("to2_sel", int'(sel1), 2);
    press(1, 0); press(1, 0); press(1, 0);
    chk("acc_pend", int'(pend1), 1);
    chk("acc_sel", int'(sel1), 2);
    vsync_pulse(p);
    chk("acc_pulses", p, 1);
    chk("acc_sel5", int'(sel1), 5);
    chk("acc_led5", int'(led1), 8'h20);

    // Wrap forward 7 -> 0 and backward 0 -> 7
    press(1, 0); press(1, 0);
    vsync_pulse(p);
    chk("to7_sel", int'(sel1), 7);
    press(1, 0);
    vsync_pulse(p);
    chk("wrap_fwd_sel", int'(sel1), 0);
    chk("wrap_fwd_led", int'(led1), 8'h01);
    press(0, 1);
    vsync_pulse(p);
    chk("wrap_back_sel", int'(sel1), 7);
    chk("wrap_back_led", int'(led1), 8'h80);

    // Next then prev cancels: no commit at the frame edge
    press(1, 0); press(0, 1);
    chk("cancel_pend", int'(pend1), 0);
    vsync_pulse(p);
    chk("cancel_pulses", p, 0);
    chk("cancel_sel", int'(sel1), 7);

    // Both keys together: no change
    press(1, 1);
    chk("both_pend", int'(pend1), 0);
    vsync_pulse(p);
    chk("both_pulses", p, 0);

    // Unsynchronised instance commits one cycle after target moves
    k0_next_n = 1'b0;
    tick(7);
    chk("nosync_pend", int'(pend0), 1);
    chk("nosync_sel_before", int'(sel0), 0);
    tick(1);
    chk("nosync_sel", int'(sel0), 1);
    chk("nosync_chg", int'(chg0), 1);
    tick(1);
    chk("nosync_chg_end", int'(chg0), 0);
    k0_next_n = 1'b1;
    tick(10);

    // No vsync: change stays pending indefinitely
    press(1, 0);
    errs = 0;
    for (int i = 0; i < 10000; i++) begin
      tick(1);
      if (!pend1 || sel1 != 4'd7) errs++;
    end
    chk("novsync_errs", errs, 0);

    // Mid-run reset with a key held down
    key_next_n = 1'b0;
    tick(20);
    sys_rst = 1'b1;
    tick(1);
    chk("midrst_sel", int'(sel1), 0);
    chk("midrst_pend", int'(pend1), 0);
    chk("midrst_led", int'(led1), 8'h01);
    sys_rst = 1'b0;
    tick(15);
    chk("post_rst_pend", int'(pend1), 1);
    key_next_n = 1'b1;
    tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mode_select_ctrl.md
Name: mode_select_ctrl

Overview:
- Upstream control stage of the video output multiplexer; generates its 4-bit processing-mode select (raw, gray, median, sobel, prewitt, sobel+erode, sobel+dilate, gesture).
- Debounces two push-buttons (next/prev), keeps a target mode, and commits it to the mux select only on a frame boundary, so a mode change never tears a frame.
- Also drives the board mode-indicator LEDs.

Parameters:
- DEB_CYCLES, 1_000_000, consecutive stable samples needed to accept a key level (20 ms at 50 MHz); bench uses 4.
- NUM_MODES, 8, number of valid modes (2..16); legal modes are 0..NUM_MODES-1.
- RESET_MODE, 0, mode after reset (raw camera); must be < NUM_MODES.
- SYNC_TO_FRAME, 1, 1 = commit at vsync rising edge; 0 = commit the cycle after target changes.

Ports:
- sys_clk  in  1  50 MHz system clock; the only clock.
- sys_rst  in  1  synchronous reset, active-high.
- key_next_n  in  1  raw button, active-low, asynchronous to sys_clk.
- key_prev_n  in  1  raw button, active-low, asynchronous to sys_clk.
- frame_vsync  in  1  camera vsync, active-high, asynchronous; rising edge = frame start.
- mode_sel  out  4  committed mode; drives the mux select.
- mode_led  out  NUM_MODES  one-hot of mode_sel.
- mode_pending  out  1  target differs from mode_sel.
- mode_changed  out  1  one-cycle pulse when mode_sel updates.

Behaviour:
- Reset (sys_rst=1 at a sys_clk edge):
  - mode_sel = target = RESET_MODE; mode_led = 1<<RESET_MODE; mode_pending = 0; mode_changed = 0.
  - Debounced key states = 1 (released); debounce counters = 0; vsync sync/edge flops = 0.
  - Mid-operation reset discards pending changes and partial debounce counts.
- Synchronisers: each key and frame_vsync passes through a 2-flop synchroniser. vsync edge = sync2 & ~sync3.
- Debounce, per key:
  - Counter increments while synced level != stable level and clears when they are equal.
  - When the counter reaches DEB_CYCLES-1 while still differing, stable takes the synced level on the next edge and the counter clears.
  - Press event = one-cycle pulse in the cycle stable goes 1->0. Release generates no event. Glitches shorter than DEB_CYCLES are rejected.
- Target update, one cycle after an event:
  - next only: target = (target==NUM_MODES-1) ? 0 : target+1.
  - prev only: target = (target==0) ? NUM_MODES-1 : target-1.
  - next and prev in the same cycle: no change.
  - Multiple presses within one frame accumulate, with wrap.
- Latency: raw key edge to target update = DEB_CYCLES+3 cycles, for a clean edge.
- Commit, SYNC_TO_FRAME=1:
  - On the cycle after a vsync edge is detected, if target != mode_sel, then mode_sel <= target and mode_changed = 1 for that cycle.
  - If a key event and a vsync edge coincide, the commit uses the pre-event target; the new target stays pending for the next frame.
  - If target == mode_sel at the vsync edge (e.g. next then prev), nothing happens and mode_changed stays 0.
- Commit, SYNC_TO_FRAME=0: mode_sel follows target with 1-cycle latency; frame_vsync is ignored.
- mode_pending is combinational: (target != mode_sel).
- mode_led is registered and updates in the same cycle as mode_sel.
- mode_sel never holds a value >= NUM_MODES. The upper bits are 0 when NUM_MODES <= 8.
- Missing vsync (camera absent): the change stays pending indefinitely; mode_pending stays 1.

Decomposition:
- Shared package vid_mode_pkg:
  - MODE_W=4.
  - Mode constants MODE_RAW=0, MODE_GRAY=1, MODE_MEDIAN=2, MODE_SOBEL=3, MODE_PREWITT=4, MODE_SOBEL_ERODE=5, MODE_SOBEL_DILATE=6, MODE_GESTURE=7, NUM_MODES_DEF=8.
  - The output mux decoder uses the same package.
- One sub-module, key_debounce (sync + counter + press pulse, parameter DEB_CYCLES), instantiated twice.
- Vsync sync/edge detection and commit logic stay in the top level.

Test Plan (DEB_CYCLES=4, NUM_MODES=8, SYNC_TO_FRAME=1 unless stated):
- Reset release -> mode_sel=0, mode_led=8'h01, mode_pending=0. Hold key_next_n low 20 cycles mid-run, assert sys_rst -> mode_sel=0, mode_pending=0 one cycle after.
- key_next_n low for 3 cycles then high -> no event; target stays 0, mode_pending=0.
- One next press, then a vsync pulse -> target=1 exactly 7 cycles after the press; mode_pending=1 until the commit. mode_sel=1, mode_led=8'h02 and mode_changed high for one cycle, the cycle after the vsync edge is detected.
- From mode 7, next -> target 0. From mode 0, prev -> target 7. Three next presses before one vsync, from mode 2 -> single commit to 5.
- Next then prev before vsync -> no mode_changed at the vsync edge; mode_sel unchanged. Both keys press simultaneously -> target unchanged.
- SYNC_TO_FRAME=0, frame_vsync held 0, one next press -> mode_sel=1 one cycle after target=1. With SYNC_TO_FRAME=1 and no vsync for 10k cycles -> mode_sel unchanged and mode_pending=1 throughout.
